// File: rtl/uart_pkg.sv
// Shared types and constants for the UART command sequencer slice.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LEN,
    ST_DATA,
    ST_CHK,
    ST_WRITE
  } state_t;

  localparam logic [1:0] ERR_CHK     = 2'd0;
  localparam logic [1:0] ERR_FRAME   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_LEN     = 2'd3;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/baud8_gen.sv
// 8x-oversampling baud tick generator: counts 0..div and pulses on the terminal count.
module baud8_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] baud8_div,
  output logic             baud8_tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] div_eff;
  logic             hit;

  // A new divider only takes hold at the start of a period (count 0); mid-period
  // changes keep the latched value so a shrinking divider cannot strand the count.
  always_comb begin
    div_eff    = (cnt_q == '0) ? baud8_div : div_q;
    div_d      = div_eff;
    hit        = (cnt_q == div_eff);
    cnt_d      = hit ? '0 : cnt_q + 1'b1;
    baud8_tick = reset_n & hit;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      div_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Frames received UART bytes into register-write bursts: SOF, ADDR, LEN, payload, XOR
// checksum; a frame is buffered whole and only replayed once its checksum matches.
module uart_cmd_sequencer
  import uart_pkg::*;
#(
  parameter int         DIV_W   = 16,
  parameter int         MAX_LEN = 16,
  parameter logic [7:0] SOF     = SOF_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] baud8_div,
  output logic             baud8_tick,
  input  logic             rx_data_ready,
  input  logic [7:0]       rx_data,
  input  logic             rx_data_error,
  input  logic             rx_endofpacket,
  output logic             wr_valid,
  input  logic             wr_ready,
  output logic [7:0]       wr_addr,
  output logic [7:0]       wr_data,
  output logic             frame_ok,
  output logic             frame_err,
  output logic [1:0]       err_code,
  output logic             rx_drop
);

  localparam int            IW  = $clog2(MAX_LEN);
  localparam int            LW  = IW + 1;
  localparam logic [LW-1:0] ONE = LW'(1);

  baud8_gen #(.DIV_W(DIV_W)) u_baud8_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .baud8_div  (baud8_div),
    .baud8_tick (baud8_tick)
  );

  state_t        state_q, state_d;
  logic [7:0]    addr_q, addr_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d, idx_inc;
  logic [7:0]    chk_q, chk_d;
  logic          wr_valid_q, wr_valid_d;
  logic [7:0]    wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q;
  logic          frame_ok_q, frame_ok_d;
  logic          frame_err_q, frame_err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          rx_drop_q, rx_drop_d;
  logic          mem_we;
  logic          rd_en;
  logic [IW-1:0] rd_addr;
  logic          idx_last;
  logic          len_ok;

  logic [7:0]    payload_mem [MAX_LEN];

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    idx_d       = idx_q;
    chk_d       = chk_q;
    wr_valid_d  = wr_valid_q;
    wr_addr_d   = wr_addr_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    rx_drop_d   = 1'b0;
    mem_we      = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = '0;
    idx_inc     = idx_q + ONE;
    idx_last    = (idx_q == len_q - ONE);
    len_ok      = (rx_data != 8'd0) && (rx_data <= 8'(MAX_LEN));

    case (state_q)
      ST_IDLE: begin
        if (rx_data_ready && (rx_data == SOF)) state_d = ST_ADDR;
      end

      ST_ADDR, ST_LEN, ST_DATA, ST_CHK: begin
        if (rx_data_error) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
          err_code_d  = ERR_FRAME;
        end else if (rx_data_ready) begin
          case (state_q)
            ST_ADDR: begin
              addr_d  = rx_data;
              chk_d   = rx_data;
              state_d = ST_LEN;
            end
            ST_LEN: begin
              if (len_ok) begin
                len_d   = rx_data[LW-1:0];
                chk_d   = chk_q ^ rx_data;
                idx_d   = '0;
                state_d = ST_DATA;
              end else begin
                state_d     = ST_IDLE;
                frame_err_d = 1'b1;
                err_code_d  = ERR_LEN;
              end
            end
            ST_DATA: begin
              mem_we = 1'b1;
              chk_d  = chk_q ^ rx_data;
              idx_d  = idx_inc;
              if (idx_last) state_d = ST_CHK;
            end
            ST_CHK: begin
              if (rx_data == chk_q) begin
                // Prefetch entry 0 so wr_data is valid together with wr_valid.
                state_d    = ST_WRITE;
                wr_valid_d = 1'b1;
                wr_addr_d  = addr_q;
                idx_d      = '0;
                rd_en      = 1'b1;
              end else begin
                state_d     = ST_IDLE;
                frame_err_d = 1'b1;
                err_code_d  = ERR_CHK;
              end
            end
            default: ;
          endcase
        end else if (rx_endofpacket) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
        end
      end

      ST_WRITE: begin
        if (rx_data_ready) rx_drop_d = 1'b1;
        if (wr_valid_q && wr_ready) begin
          if (idx_last) begin
            wr_valid_d = 1'b0;
            frame_ok_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            idx_d     = idx_inc;
            wr_addr_d = wr_addr_q + 8'd1;
            rd_en     = 1'b1;
            rd_addr   = idx_inc[IW-1:0];
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Payload storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (mem_we) payload_mem[idx_q[IW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      chk_q       <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_CHK;
      rx_drop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      chk_q       <= chk_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      rx_drop_q   <= rx_drop_d;
      if (rd_en) wr_data_q <= payload_mem[rd_addr];
    end
  end

  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign rx_drop   = rx_drop_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Self-checking bench for uart_cmd_sequencer: directed frames plus randomized frames
// checked against a frame-level reference model (address = base + i, data = payload).
module tb_uart_cmd_sequencer;

  localparam int DIV_W   = 16;
  localparam int MAX_LEN = 16;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [DIV_W-1:0] baud8_div = '0;
  logic             baud8_tick;
  logic             rx_data_ready = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_data_error = 1'b0;
  logic             rx_endofpacket = 1'b0;
  logic             wr_valid;
  logic             wr_ready = 1'b0;
  logic [7:0]       wr_addr;
  logic [7:0]       wr_data;
  logic             frame_ok;
  logic             frame_err;
  logic [1:0]       err_code;
  logic             rx_drop;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_cmd_sequencer #(.DIV_W(DIV_W), .MAX_LEN(MAX_LEN), .SOF(8'hA5)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .baud8_div      (baud8_div),
    .baud8_tick     (baud8_tick),
    .rx_data_ready  (rx_data_ready),
    .rx_data        (rx_data),
    .rx_data_error  (rx_data_error),
    .rx_endofpacket (rx_endofpacket),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .frame_ok       (frame_ok),
    .frame_err      (frame_err),
    .err_code       (err_code),
    .rx_drop        (rx_drop)
  );

  // Observer: records handshakes, pulses and hold-stability on the falling edge.
  logic [7:0] hs_addr[$];
  logic [7:0] hs_data[$];
  int         hs_cyc[$];
  int         cyc = 0;
  int         ok_cnt = 0, err_cnt = 0, drop_cnt = 0, stall_viol = 0, ok_cyc = 0;
  logic [1:0] last_err = 2'd0;
  logic       prev_v = 1'b0;
  logic [7:0] prev_a = 8'h00, prev_d = 8'h00;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!reset_n) begin
      prev_v <= 1'b0;
    end else begin
      if (prev_v && !(wr_valid === 1'b1 && wr_addr == prev_a && wr_data == prev_d))
        stall_viol <= stall_viol + 1;
      if (wr_valid && wr_ready) begin
        hs_addr.push_back(wr_addr);
        hs_data.push_back(wr_data);
        hs_cyc.push_back(cyc);
        prev_v <= 1'b0;
      end else begin
        prev_v <= wr_valid;
        prev_a <= wr_addr;
        prev_d <= wr_data;
      end
      if (frame_ok) begin
        ok_cnt <= ok_cnt + 1;
        ok_cyc <= cyc;
      end
      if (frame_err) begin
        err_cnt  <= err_cnt + 1;
        last_err <= err_code;
      end
      if (rx_drop) drop_cnt <= drop_cnt + 1;
    end
  end

  // wr_ready patterns: 0 always, 1 one-in-three, 2 random, 3 never.
  int ready_mode = 0;
  int rdy_phase = 0;
  always @(posedge clk) begin
    #1;
    rdy_phase <= (rdy_phase == 2) ? 0 : rdy_phase + 1;
    case (ready_mode)
      0:       wr_ready <= 1'b1;
      1:       wr_ready <= (rdy_phase == 2);
      2:       wr_ready <= ($urandom_range(0, 1) == 1);
      default: wr_ready <= 1'b0;
    endcase
  end

  logic [7:0] tx_pl [64];
  int ok0, err0, hs0, drop0, sv0, last_send_cyc;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    ok0 = ok_cnt; err0 = err_cnt; hs0 = hs_addr.size(); drop0 = drop_cnt; sv0 = stall_viol;
  endtask

  task automatic pulse(input logic rdy, input logic err, input logic eop, input logic [7:0] b);
    rx_data = b; rx_data_ready = rdy; rx_data_error = err; rx_endofpacket = eop;
    last_send_cyc = cyc;
    step();
    rx_data_ready = 1'b0; rx_data_error = 1'b0; rx_endofpacket = 1'b0;
    step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    pulse(1'b1, 1'b0, 1'b0, b);
  endtask

  function automatic logic [7:0] calc_chk(input logic [7:0] a, input int n);
    logic [7:0] c;
    c = a ^ 8'(n);
    for (int i = 0; i < n; i++) c = c ^ tx_pl[i];
    return c;
  endfunction

  task automatic send_frame(input logic [7:0] a, input logic [7:0] lenb, input int n,
                            input logic [7:0] chk);
    send_byte(8'hA5);
    send_byte(a);
    send_byte(lenb);
    for (int i = 0; i < n; i++) send_byte(tx_pl[i]);
    send_byte(chk);
  endtask

  task automatic wait_frame(input string name);
    int n;
    n = 0;
    while (ok_cnt == ok0 && err_cnt == err0 && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) begin
      checks++; failures++;
      $display("FAIL %s timeout: no frame_ok/frame_err in 400 cycles", name);
    end
    step(); step();
  endtask

  task automatic expect_ok(input string name, input logic [7:0] a, input int n);
    logic [7:0] ea;
    wait_frame(name);
    checks++;
    if (ok_cnt != ok0 + 1 || err_cnt != err0) begin
      failures++;
      $display("FAIL %s counts: frame_ok=%0d frame_err=%0d, want 1 and 0", name, ok_cnt - ok0, err_cnt - err0);
    end
    checks++;
    if (hs_addr.size() != hs0 + n) begin
      failures++;
      $display("FAIL %s writes: got %0d want %0d", name, hs_addr.size() - hs0, n);
    end else begin
      for (int i = 0; i < n; i++) begin
        ea = a + 8'(i);
        checks++;
        if (hs_addr[hs0+i] !== ea || hs_data[hs0+i] !== tx_pl[i]) begin
          failures++;
          $display("FAIL %s write%0d: got (%h,%h) want (%h,%h)", name, i, hs_addr[hs0+i], hs_data[hs0+i], ea, tx_pl[i]);
        end
      end
    end
    checks++;
    if (stall_viol != sv0) begin
      failures++;
      $display("FAIL %s hold: %0d unstable/dropped wr_valid cycles, want 0", name, stall_viol - sv0);
    end
    $display("tb: %s addr=%h len=%0d writes=%0d", name, a, n, hs_addr.size() - hs0);
  endtask

  task automatic expect_err(input string name, input logic [1:0] code);
    wait_frame(name);
    checks++;
    if (err_cnt != err0 + 1 || ok_cnt != ok0 || last_err !== code) begin
      failures++;
      $display("FAIL %s: frame_err=%0d frame_ok=%0d err_code=%0d, want 1 0 %0d", name, err_cnt - err0, ok_cnt - ok0, last_err, code);
    end
    checks++;
    if (hs_addr.size() != hs0) begin
      failures++;
      $display("FAIL %s: %0d writes issued, want 0", name, hs_addr.size() - hs0);
    end
    $display("tb: %s err_code=%0d", name, last_err);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    baud8_div = '0;
    reset_n = 1'b0;
    step(); step();
    checks++;
    if ({baud8_tick, wr_valid, frame_ok, frame_err, rx_drop} !== 5'b0 ||
        wr_addr !== 8'h00 || wr_data !== 8'h00 || err_code !== 2'd0) begin
      failures++;
      $display("FAIL reset: tick=%b valid=%b addr=%h data=%h ok=%b err=%b code=%0d drop=%b, want all 0",
               baud8_tick, wr_valid, wr_addr, wr_data, frame_ok, frame_err, err_code, rx_drop);
    end
    $display("tb: reset outputs checked");
  endtask

  task automatic test_baud();
    int cnt_m, cur_div, div_in;
    logic exp_tick;
    int ticks[$];
    int want[8] = '{4, 9, 14, 17, 20, 23, 26, 29};
    reset_n = 1'b0;
    baud8_div = 16'd4;
    div_in = 4;
    step(); step();
    reset_n = 1'b1;
    cnt_m = 0; cur_div = 0;
    for (int s = 0; s < 30; s++) begin
      @(negedge clk);
      if (cnt_m == 0) cur_div = div_in;
      exp_tick = (cnt_m == cur_div);
      cnt_m = exp_tick ? 0 : cnt_m + 1;
      if (baud8_tick === 1'b1) ticks.push_back(s);
      checks++;
      if (baud8_tick !== exp_tick) begin
        failures++;
        $display("FAIL baud sample %0d: tick=%b want %b", s, baud8_tick, exp_tick);
      end
      if (s == 11) begin
        baud8_div = 16'd2;
        div_in = 2;
      end
    end
    checks++;
    if (ticks.size() != 8) begin
      failures++;
      $display("FAIL baud tick count: got %0d want 8", ticks.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (ticks[i] != want[i]) begin
          failures++;
          $display("FAIL baud tick%0d: at sample %0d want %0d", i, ticks[i], want[i]);
        end
      end
    end
    $display("tb: baud ticks=%0d", ticks.size());
    @(posedge clk);
    #1;
  endtask

  task automatic test_good_frame();
    ready_mode = 0;
    tx_pl[0] = 8'h11; tx_pl[1] = 8'h22;
    snap();
    send_frame(8'h10, 8'h02, 2, 8'h21);
    expect_ok("good_frame", 8'h10, 2);
    if (hs_addr.size() == hs0 + 2) begin
      checks++;
      if (hs_cyc[hs0] != last_send_cyc + 1 || hs_cyc[hs0+1] != hs_cyc[hs0] + 1 || ok_cyc != hs_cyc[hs0+1] + 1) begin
        failures++;
        $display("FAIL good_frame timing: chk@%0d hs@%0d,%0d ok@%0d, want hs at chk+1,+2 and ok at +3",
                 last_send_cyc, hs_cyc[hs0], hs_cyc[hs0+1], ok_cyc);
      end
    end
  endtask

  task automatic test_bad_chk();
    tx_pl[0] = 8'h11; tx_pl[1] = 8'h22;
    snap();
    send_frame(8'h10, 8'h02, 2, 8'h20);
    expect_err("bad_chk", 2'd0);
  endtask

  task automatic test_len_bounds();
    snap();
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h00);
    expect_err("len_zero", 2'd3);
    snap();
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'(MAX_LEN + 1));
    expect_err("len_over", 2'd3);
    for (int i = 0; i < MAX_LEN; i++) tx_pl[i] = 8'(8'hC0 + i);
    snap();
    send_frame(8'h30, 8'(MAX_LEN), MAX_LEN, calc_chk(8'h30, MAX_LEN));
    expect_ok("len_max", 8'h30, MAX_LEN);
  endtask

  task automatic test_line_events();
    snap();
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'h11);
    pulse(1'b0, 1'b0, 1'b1, 8'h00);
    expect_err("eop_in_data", 2'd2);
    snap();
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03); send_byte(8'h11);
    pulse(1'b0, 1'b1, 1'b0, 8'h00);
    expect_err("rxerr_in_data", 2'd1);
    snap();
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03);
    pulse(1'b1, 1'b1, 1'b1, 8'h11);
    expect_err("rxerr_beats_ready", 2'd1);
    snap();
    pulse(1'b0, 1'b1, 1'b1, 8'h00);
    step(); step();
    checks++;
    if (err_cnt != err0 || ok_cnt != ok0) begin
      failures++;
      $display("FAIL idle_events: frame_err=%0d frame_ok=%0d want 0 0", err_cnt - err0, ok_cnt - ok0);
    end
    $display("tb: idle_events ignored");
    tx_pl[0] = 8'h5A; tx_pl[1] = 8'h6B;
    snap();
    send_byte(8'hA5); send_byte(8'h20);
    pulse(1'b1, 1'b0, 1'b1, 8'h02);
    send_byte(8'h5A); send_byte(8'h6B); send_byte(calc_chk(8'h20, 2));
    expect_ok("ready_beats_eop", 8'h20, 2);
  endtask

  task automatic test_wrap_stall_drop();
    ready_mode = 1;
    tx_pl[0] = 8'h01; tx_pl[1] = 8'h02; tx_pl[2] = 8'h03;
    snap();
    send_frame(8'hFF, 8'h03, 3, calc_chk(8'hFF, 3));
    send_byte(8'hA5);
    expect_ok("wrap_stall", 8'hFF, 3);
    checks++;
    if (drop_cnt != drop0 + 1) begin
      failures++;
      $display("FAIL rx_drop: got %0d pulses want 1", drop_cnt - drop0);
    end
    ready_mode = 0;
  endtask

  task automatic test_random_frames();
    logic [7:0] a, chk;
    int n;
    bit corrupt;
    ready_mode = 2;
    for (int f = 0; f < 12; f++) begin
      a = 8'($urandom);
      n = $urandom_range(1, MAX_LEN);
      corrupt = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < n; i++) tx_pl[i] = 8'($urandom);
      chk = calc_chk(a, n);
      if (corrupt) chk = chk ^ (8'h01 << $urandom_range(0, 7));
      snap();
      for (int g = $urandom_range(0, 2); g > 0; g--) send_byte(8'($urandom_range(0, 8'hA4)));
      send_frame(a, 8'(n), n, chk);
      if (corrupt) expect_err("rand_badchk", 2'd0);
      else expect_ok("rand_frame", a, n);
    end
    ready_mode = 0;
  endtask

  task automatic test_reset_mid_write();
    ready_mode = 3;
    for (int i = 0; i < 4; i++) tx_pl[i] = 8'(8'h90 + i);
    send_frame(8'h40, 8'h04, 4, calc_chk(8'h40, 4));
    checks++;
    if (wr_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_write setup: wr_valid=%b want 1", wr_valid);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (wr_valid !== 1'b0 || wr_addr !== 8'h00 || wr_data !== 8'h00) begin
      failures++;
      $display("FAIL mid_write reset: valid=%b addr=%h data=%h want 0 00 00", wr_valid, wr_addr, wr_data);
    end
    step();
    reset_n = 1'b1;
    ready_mode = 0;
    step();
    tx_pl[0] = 8'h77; tx_pl[1] = 8'h88;
    snap();
    send_frame(8'h50, 8'h02, 2, calc_chk(8'h50, 2));
    expect_ok("after_reset", 8'h50, 2);
  endtask

  initial begin
    test_reset();
    test_baud();
    do_reset();
    test_good_frame();
    test_bad_chk();
    test_len_bounds();
    test_line_events();
    test_wrap_stall_drop();
    test_random_frames();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
